// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one shift/add-subtract step per cycle,
// with sign pre/post correction around an unsigned core and a stall request toward the hazard unit.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_RUN   = 2'd2,
    S_FIXUP = 2'd3
  } state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;    // raw dividend, kept for the divide-by-zero result
  logic [WIDTH-1:0] b_q;    // raw src_b, then |b| (multiplicand / divisor)
  logic [WIDTH-1:0] rem_q;  // product high half / partial remainder
  logic [WIDTH-1:0] quo_q;  // multiplier -> product low half / dividend -> quotient
  logic             neg_q, rneg_q, dz_q;

  logic               sa, sb, div_zero;
  logic [WIDTH:0]     shifted, opx;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH+1:0]   opy, alu;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // op[0]==0 selects the signed variants (MULT, DIV)
  assign sa       = ~op_q[0] & a_q[WIDTH-1];
  assign sb       = ~op_q[0] & b_q[WIDTH-1];
  assign div_zero = op_q[1] && (b_q == '0);

  // Shared adder: divide computes shifted - divisor (borrow in top bit), multiply adds the
  // multiplicand into the high half when the current multiplier bit is set.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    addend  = quo_q[0] ? b_q : '0;
    opx     = op_q[1] ? shifted : {1'b0, rem_q};
    opy     = op_q[1] ? ~{2'b00, b_q} : {2'b00, addend};
    alu     = {1'b0, opx} + opy + {{(WIDTH+1){1'b0}}, op_q[1]};
    if (op_q[1]) begin
      if (alu[WIDTH+1]) begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = alu[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      rem_d = alu[WIDTH:1];
      quo_d = {alu[0], quo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = cneg_2w({rem_q, quo_q}, neg_q);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (dz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (op_q[1]) begin
      fix_hi = cneg_w(rem_q, rneg_q);
      fix_lo = cneg_w(quo_q, neg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            op_q    <= op;
            a_q     <= src_a;
            b_q     <= src_b;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            quo_q   <= cneg_w(a_q, sa);
            b_q     <= cneg_w(b_q, sb);
            rem_q   <= '0;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            dz_q    <= div_zero;
            cnt_q   <= CNT_LAST;
            state_q <= div_zero ? S_FIXUP : S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) state_q <= S_FIXUP;
            else             cnt_q   <= cnt_q - CW'(1);
          end
        end
        S_FIXUP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!abort) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (start | hilo_rd);

endmodule
